// File: rtl/stream_mux_pkg.sv
// Shared constants, width helpers and arbiter state type for the
// N-channel stream merge stage.
package stream_mux_pkg;
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
endpackage

// File: rtl/stream_sync_fifo.sv
// Per-channel synchronous FIFO; occupancy is a registered count one bit
// wider than the pointers so full and empty are unambiguous.
module stream_sync_fifo
  import stream_mux_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = lvl_w(DEPTH)
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
  logic              do_push, do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_clk) begin
    if (reset_reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/stream_channel_mux.sv
// N-channel Avalon-ST merge: per-channel FIFOs drained by a burst-limited
// round-robin or fixed-priority arbiter into one registered, tagged stream.
module stream_channel_mux
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int BURST_MAX = 8,
  localparam int CH_W  = idx_w(CHANNELS),
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS-1:0]       ch_enable,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [CH_W-1:0]           out_channel,
  input  logic                      out_ready,
  output logic [CHANNELS*LVL_W-1:0] fill_level
);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  logic [CHANNELS-1:0]             full, empty, elig, pop;
  logic [CHANNELS-1:0][DATA_W-1:0] rdata;

  arb_state_e       state, state_nxt;
  logic [CH_W-1:0]  cur_ch, cur_nxt, pop_ch, win, win_lo, win_hi;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             found_lo, found_hi, can_load, do_pop;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Disabled channels always accept so upstream never stalls on them.
    assign in_ready[c] = !reset_reset && (ch_enable[c] ? !full[c] : 1'b1);
    assign elig[c]     = ch_enable[c] && !empty[c];

    stream_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_clk     (clk_clk),
      .reset_reset (reset_reset),
      .push        (in_valid[c] && ch_enable[c]),
      .pop         (pop[c]),
      .flush       (!ch_enable[c]),
      .wdata       (in_data[c*DATA_W +: DATA_W]),
      .rdata       (rdata[c]),
      .full        (full[c]),
      .empty       (empty[c]),
      .level       (fill_level[c*LVL_W +: LVL_W])
    );
  end

  // cur_ch doubles as the last-granted pointer; the RR winner is the first
  // eligible index above it, else the lowest eligible index (wrap).
  always_comb begin
    win_lo   = '0;
    found_lo = 1'b0;
    win_hi   = '0;
    found_hi = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_lo   = CH_W'(i);
        found_lo = 1'b1;
      end
      if (elig[i] && (i > int'(cur_ch))) begin
        win_hi   = CH_W'(i);
        found_hi = 1'b1;
      end
    end
    win = (PRIO_MODE == PRIO_RR && found_hi) ? win_hi : win_lo;
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_ch;
    cnt_nxt   = cnt;
    do_pop    = 1'b0;
    pop_ch    = cur_ch;
    can_load  = !out_valid || out_ready;
    if (can_load) begin
      if (state == ARB_BURST && elig[cur_ch] && cnt < BURST_LIM) begin
        do_pop  = 1'b1;
        cnt_nxt = cnt + 1'b1;
      end else if (found_lo) begin
        do_pop    = 1'b1;
        pop_ch    = win;
        state_nxt = ARB_BURST;
        cur_nxt   = win;
        cnt_nxt   = CNT_W'(1);
      end else begin
        state_nxt = ARB_IDLE;
      end
    end else if (state == ARB_BURST && !ch_enable[cur_ch]) begin
      state_nxt = ARB_IDLE;
    end
    pop = do_pop ? (CHANNELS'(1) << pop_ch) : '0;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= ARB_IDLE;
      cur_ch      <= CH_W'(CHANNELS - 1);
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
    end else begin
      state  <= state_nxt;
      cur_ch <= cur_nxt;
      cnt    <= cnt_nxt;
      if (do_pop) begin
        out_valid   <= 1'b1;
        out_data    <= rdata[pop_ch];
        out_channel <= pop_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stream_channel_mux.sv
// Scoreboard bench: DUT 0 is round-robin, DUT 1 fixed priority, both with
// BURST_MAX=2; per-channel expected queues are filled on input handshakes.
module tb_stream_channel_mux;
  localparam int CH    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BM    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk, rst;
  logic [1:0][CH-1:0]    in_valid, in_ready, en, acc;
  logic [1:0][CH*DW-1:0] in_data;
  logic [1:0]            out_valid, out_ready;
  logic [1:0][DW-1:0]    out_data;
  logic [1:0][1:0]       out_channel;
  logic [1:0][CH*LW-1:0] fill;

  logic [31:0] exp_q [2][CH][$];
  int          trace [2][$];
  bit          trace_en;
  int          checks, failures;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    stream_channel_mux #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH),
                         .PRIO_MODE(d), .BURST_MAX(BM)) u_dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .in_valid    (in_valid[d]),
      .in_data     (in_data[d]),
      .in_ready    (in_ready[d]),
      .ch_enable   (en[d]),
      .out_valid   (out_valid[d]),
      .out_data    (out_data[d]),
      .out_channel (out_channel[d]),
      .out_ready   (out_ready[d]),
      .fill_level  (fill[d])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Input capture and output scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    int ch;
    for (int d = 0; d < 2; d++) begin
      acc[d] <= in_valid[d] & in_ready[d];
      for (int c = 0; c < CH; c++)
        if (in_valid[d][c] && in_ready[d][c] && en[d][c])
          exp_q[d][c].push_back(in_data[d][c*DW +: DW]);
      if (trace_en)
        trace[d].push_back((!rst && out_valid[d] && out_ready[d]) ? int'(out_channel[d]) : -1);
      if (!rst && out_valid[d] && out_ready[d]) begin
        ch = int'(out_channel[d]);
        if (exp_q[d][ch].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected dut=%0d ch=%0d got=%0h exp=none", d, ch, out_data[d]);
        end else begin
          chk($sformatf("sb_data_d%0d_ch%0d", d, ch), out_data[d], exp_q[d][ch].pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        if (acc[d][c] === 1'b1) in_data[d][c*DW +: DW] = $urandom;
  endtask

  task automatic chk_reset(input int d);
    chk("rst_out_valid", 32'(out_valid[d]), 0);
    chk("rst_out_data", out_data[d], 0);
    chk("rst_out_channel", 32'(out_channel[d]), 0);
    chk("rst_in_ready", 32'(in_ready[d]), 0);
    chk("rst_fill", 32'(fill[d]), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) exp_q[d][c].delete();
    step();
    chk_reset(0);
    rst = 1'b0;
  endtask

  task automatic clear_trace();
    trace[0].delete();
    trace[1].delete();
  endtask

  initial begin
    int nacc, sum, n0, n3, nrem;
    checks = 0; failures = 0; trace_en = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = '0; in_data[d] = '0; en[d] = '1; out_ready[d] = 1'b1;
    end
    step(); step();
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    step();

    // Single word on ch2: visible two cycles after its handshake.
    in_valid[0][2] = 1'b1;
    in_data[0][2*DW +: DW] = 32'hA5A5_0001;
    step();
    in_valid[0] = '0;
    chk("lat_k1_valid", 32'(out_valid[0]), 0);
    step();
    chk("lat_k2_valid", 32'(out_valid[0]), 1);
    chk("lat_k2_data", out_data[0], 32'hA5A5_0001);
    chk("lat_k2_channel", 32'(out_channel[0]), 2);
    step(); step();

    // Half-fill all channels under backpressure, then reset mid-stream.
    out_ready[0] = 1'b0;
    in_valid[0] = '1;
    repeat (8) step();
    in_valid[0] = '0;
    step();
    sum = 0;
    for (int c = 0; c < CH; c++) sum += int'(fill[0][c*LW +: LW]);
    chk("half_fill_sum", sum, 4 * 8 - 1);
    do_reset();

    // RR fairness: 4 words per channel, order (k/BM)%CH with no idle cycle.
    in_valid[0] = '1;
    repeat (4) step();
    in_valid[0] = '0;
    step(); step();
    clear_trace();
    trace_en = 1'b1;
    out_ready[0] = 1'b1;
    repeat (18) step();
    trace_en = 1'b0;
    for (int k = 0; k < 16; k++) chk($sformatf("rr_order_%0d", k), trace[0][k], (k / BM) % CH);
    chk("rr_idle_after", trace[0][16], -1);

    // Full FIFO: DEPTH words stored plus one in the output register.
    out_ready[0] = 1'b0;
    in_valid[0] = 4'b0010;
    nacc = 0;
    for (int i = 0; i < 40 && in_ready[0][1]; i++) begin
      step();
      if (acc[0][1] === 1'b1) nacc++;
    end
    chk("full_accepted", nacc, DEPTH + 1);
    chk("full_fill", 32'(fill[0][1*LW +: LW]), DEPTH);
    chk("full_in_ready", 32'(in_ready[0][1]), 0);
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    chk("full_reready", 32'(in_ready[0][1]), 1);
    in_valid[0] = '0;
    out_ready[0] = 1'b1;
    repeat (25) step();

    // Disable ch1 while it holds the output register and has 5 queued.
    do_reset();
    out_ready[0] = 1'b0;
    in_valid[0] = 4'b0110;
    repeat (3) step();
    in_valid[0] = 4'b0010;
    repeat (3) step();
    in_valid[0] = '0;
    step();
    chk("dis_fill1_before", 32'(fill[0][1*LW +: LW]), 5);
    chk("dis_fill2_before", 32'(fill[0][2*LW +: LW]), 3);
    en[0][1] = 1'b0;
    while (exp_q[0][1].size() > 1) void'(exp_q[0][1].pop_back());
    in_valid[0][1] = 1'b1;
    step();
    in_valid[0] = '0;
    chk("dis_fill1_after", 32'(fill[0][1*LW +: LW]), 0);
    chk("dis_in_ready1", 32'(in_ready[0][1]), 1);
    clear_trace();
    trace_en = 1'b1;
    out_ready[0] = 1'b1;
    repeat (6) step();
    trace_en = 1'b0;
    chk("dis_seq_0", trace[0][0], 1);
    for (int k = 1; k < 4; k++) chk($sformatf("dis_seq_%0d", k), trace[0][k], 2);
    chk("dis_seq_4", trace[0][4], -1);
    en[0][1] = 1'b1;

    // Fixed priority: ch0 starves ch3 until it stops, then ch3 without a gap.
    clear_trace();
    in_valid[1] = 4'b1001;
    trace_en = 1'b1;
    repeat (30) step();
    trace_en = 1'b0;
    n0 = 0; n3 = 0;
    foreach (trace[1][k]) begin
      if (trace[1][k] == 0) n0++;
      if (trace[1][k] == 3) n3++;
    end
    chk("fp_ch0_count", n0, 28);
    chk("fp_ch3_count", n3, 0);
    in_valid[1][0] = 1'b0;
    nrem = exp_q[1][0].size();
    clear_trace();
    trace_en = 1'b1;
    repeat (10) step();
    trace_en = 1'b0;
    for (int k = 0; k < 10; k++) chk($sformatf("fp_switch_%0d", k), trace[1][k], (k < nrem) ? 0 : 3);
    in_valid[1] = '0;
    repeat (25) step();

    // Random traffic on both arbiters.
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 2; d++) begin
        in_valid[d]  = CH'($urandom);
        out_ready[d] = ($urandom_range(3) != 0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = '0;
      out_ready[d] = 1'b1;
    end
    repeat (80) step();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        chk($sformatf("drain_d%0d_ch%0d", d, c), exp_q[d][c].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
